// File: rtl/mem_bus_arbiter.sv
// Arbitrates one external memory bus between ICache refill, DCache refill and DCache writeback bursts.
// Define MEM_ARB_RR_EN to alternate priority between the two read requesters (writeback stays on top).
module mem_bus_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_rreq,
  input  logic [ADDR_W-1:0] icache_raddr,
  output logic              icache_rvalid,
  output logic              icache_rlast,
  output logic [DATA_W-1:0] icache_rdata,
  input  logic              dcache_rreq,
  input  logic [ADDR_W-1:0] dcache_raddr,
  output logic              dcache_rvalid,
  output logic              dcache_rlast,
  output logic [DATA_W-1:0] dcache_rdata,
  input  logic              dcache_wreq,
  input  logic [ADDR_W-1:0] dcache_waddr,
  input  logic [DATA_W-1:0] dcache_wdata,
  output logic              dcache_wnext,
  output logic              dcache_wdone,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_len,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic              bus_rlast,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_wvalid,
  output logic              bus_wlast,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_wready,
  input  logic              bus_bvalid
);
  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_R_ADDR = 3'd1;
  localparam logic [2:0] S_R_DATA = 3'd2;
  localparam logic [2:0] S_W_ADDR = 3'd3;
  localparam logic [2:0] S_W_DATA = 3'd4;
  localparam logic [2:0] S_W_RESP = 3'd5;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IC   = 2'd1;
  localparam logic [1:0] OWN_DC   = 2'd2;

  logic [2:0]        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wdone_q, wdone_d;
  logic              wreq_eff;
  logic              pick_dc_rd;
  logic              rd_fwd;

`ifdef MEM_ARB_RR_EN
  logic last_ic_q, last_ic_d;
  assign pick_dc_rd = dcache_rreq & (last_ic_q | ~icache_rreq);
`else
  assign pick_dc_rd = dcache_rreq;
`endif

  // The writeback requester only drops its level after seeing wdone, so ignore it during that cycle.
  assign wreq_eff = dcache_wreq & ~wdone_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wdone_d = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_ic_d = last_ic_q;
`endif
    case (state_q)
      S_IDLE: begin
        owner_d = OWN_NONE;
        if (wreq_eff) begin
          state_d = S_W_ADDR;
          owner_d = OWN_DC;
          addr_d  = dcache_waddr;
        end else if (pick_dc_rd) begin
          state_d = S_R_ADDR;
          owner_d = OWN_DC;
          addr_d  = dcache_raddr;
`ifdef MEM_ARB_RR_EN
          last_ic_d = 1'b0;
`endif
        end else if (icache_rreq) begin
          state_d = S_R_ADDR;
          owner_d = OWN_IC;
          addr_d  = icache_raddr;
`ifdef MEM_ARB_RR_EN
          last_ic_d = 1'b1;
`endif
        end
      end
      S_R_ADDR: if (bus_gnt) state_d = S_R_DATA;
      S_R_DATA: begin
        if (bus_rvalid & bus_rlast) begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
        end
      end
      S_W_ADDR: begin
        if (bus_gnt) begin
          state_d = S_W_DATA;
          cnt_d   = '0;
        end
      end
      S_W_DATA: begin
        if (bus_wready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_W_RESP;
        end
      end
      S_W_RESP: begin
        if (bus_bvalid) begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
          wdone_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= OWN_NONE;
      addr_q  <= '0;
      cnt_q   <= '0;
      wdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      wdone_q <= wdone_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Reset to "IC served last" so the DCache wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_ic_q <= 1'b1;
    else     last_ic_q <= last_ic_d;
  end
`endif

  assign bus_req  = (state_q == S_R_ADDR) | (state_q == S_W_ADDR);
  assign bus_we   = (state_q == S_W_ADDR);
  assign bus_addr = bus_req ? addr_q : '0;
  assign bus_len  = bus_req ? 8'(LINE_WORDS - 1) : 8'd0;

  assign rd_fwd        = (state_q == S_R_DATA) & bus_rvalid;
  assign icache_rvalid = rd_fwd & (owner_q == OWN_IC);
  assign icache_rlast  = icache_rvalid & bus_rlast;
  assign icache_rdata  = icache_rvalid ? bus_rdata : '0;
  assign dcache_rvalid = rd_fwd & (owner_q == OWN_DC);
  assign dcache_rlast  = dcache_rvalid & bus_rlast;
  assign dcache_rdata  = dcache_rvalid ? bus_rdata : '0;

  assign bus_wvalid   = (state_q == S_W_DATA);
  assign bus_wlast    = bus_wvalid & (cnt_q == CNT_LAST);
  assign bus_wdata    = bus_wvalid ? dcache_wdata : '0;
  assign dcache_wnext = bus_wvalid & bus_wready;
  assign dcache_wdone = wdone_q;
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates the single external memory bus between the ICache refill port and the DCache refill and writeback ports. It sequences whole-line burst transactions, one at a time, and steers bus beats back to the owning requester. The DCache ready and stall handshake seen by the MEM stage is produced from this block's `dcache_rlast` and `dcache_wdone`. Sits between the two caches and the bus interface unit.

## Interface
- `LINE_WORDS`, default 4: beats per burst; a power of two, minimum 2.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: beat width (`WORD`).

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `icache_rreq` in 1: ICache line-read request (level).
- `icache_raddr` in ADDR_W: line-aligned address.
- `icache_rvalid` / `icache_rlast` out 1: read beat valid / last beat.
- `icache_rdata` out DATA_W: beat data.
- `dcache_rreq` in 1, `dcache_raddr` in ADDR_W: DCache refill request and address.
- `dcache_rvalid` / `dcache_rlast` out 1, `dcache_rdata` out DATA_W: DCache refill beats.
- `dcache_wreq` in 1, `dcache_waddr` in ADDR_W: DCache writeback request and address.
- `dcache_wdata` in DATA_W: current writeback beat.
- `dcache_wnext` out 1: current beat consumed; the DCache presents the next beat in the following cycle.
- `dcache_wdone` out 1: writeback acknowledged.
- `bus_req` out 1: address phase valid.
- `bus_we` out 1: 1 means write burst.
- `bus_addr` out ADDR_W: burst address.
- `bus_len` out 8: burst length, fixed at LINE_WORDS-1.
- `bus_gnt` in 1: address phase accepted.
- `bus_rvalid` / `bus_rlast` in 1, `bus_rdata` in DATA_W: read beats.
- `bus_wvalid` / `bus_wlast` out 1, `bus_wdata` out DATA_W: write beats.
- `bus_wready` in 1: write beat accepted.
- `bus_bvalid` in 1: write response.

## Operation

FSM states: IDLE, R_ADDR, R_DATA, W_ADDR, W_DATA, W_RESP.

Owner register values: NONE, IC, DC.

**IDLE**
- Samples the requests. Priority: `dcache_wreq` > `dcache_rreq` > `icache_rreq`.
- A winning write goes to W_ADDR. A winning read goes to R_ADDR. Owner and address are latched.

**R_ADDR**
- Drives `bus_req`=1, `bus_we`=0, `bus_addr`=latched address.
- Moves to R_DATA on `bus_gnt`.

**R_DATA**
- Each `bus_rvalid` is forwarded combinationally to the owner's `rvalid`/`rdata`/`rlast`. The non-owner's outputs are held at 0.
- Returns to IDLE on `bus_rvalid & bus_rlast`.

**W_ADDR**
- Drives `bus_req`=1, `bus_we`=1.
- On `bus_gnt`: moves to W_DATA and clears the beat counter (log2(LINE_WORDS) bits).

**W_DATA**
- `bus_wvalid`=1 and `bus_wdata`=`dcache_wdata`.
- `bus_wlast`=1 when the counter equals LINE_WORDS-1.
- `dcache_wnext`=`bus_wready`.
- The counter increments on each `bus_wready`.
- Moves to W_RESP on `bus_wready & bus_wlast`.

**W_RESP**
- On `bus_bvalid`: pulses `dcache_wdone` for 1 cycle and returns to IDLE.

**Rules**
- Requests are levels and must be held until `rlast` or `wdone`. Deasserting mid-transaction is ignored; the burst still completes.
- A granted transaction is never pre-empted.
- After completion the FSM always spends at least one cycle in IDLE before the next grant, including back-to-back requests from the same requester.
- The address is latched at grant. Input address changes after grant have no effect.

## Timing
- On reset, every output is 0, the FSM is in IDLE, the owner is NONE and the counter is 0.
- Reset mid-burst aborts immediately. No partial beat is forwarded after reset.
- A request asserted in cycle N with the FSM in IDLE produces `bus_req`=1 in cycle N+1. `bus_req` is registered from the FSM state.
- Read data passes through with zero latency from the `bus_rvalid` cycle to the owner's `rvalid` cycle.
- Minimum read transaction: 1 (IDLE) + 1 (addr, `bus_gnt` same cycle) + LINE_WORDS cycles.
- Minimum write transaction: 1 + 1 + LINE_WORDS + 1 (resp).
- If all three requests arrive in the same cycle, the grant order is DC write, then DC read, then IC. The victim is therefore written back before the refill of the same set.
- `bus_rvalid` outside R_DATA is ignored. `bus_bvalid` outside W_RESP is ignored.

## Configuration
- Macro: `MEM_ARB_RR_EN`.
- Defined:
  - Between `dcache_rreq` and `icache_rreq`, a 1-bit last-served pointer alternates priority. The pointer is updated at each read grant.
  - `dcache_wreq` remains top priority.
  - The pointer resets to "IC last", so the DCache wins the first tie.
- Undefined: fixed priority, `dcache_rreq` > `icache_rreq`; no pointer register.

## Test plan
- **Lone ICache read:** reset, then `icache_rreq`=1 at address 0x1C000040; bus returns beats 0xA0..0xA3 with `bus_gnt` on the first address cycle.
  - `bus_req` rises 1 cycle after the request, with `bus_we`=0 and `bus_addr`=0x1C000040.
  - `icache_rvalid` fires 4 times, with `icache_rlast` on 0xA3.
  - `dcache_rvalid` stays 0 throughout.
- **Writeback with stalls:** `dcache_wreq` at 0x80, data 0x11..0x44, `bus_wready` low on the 2nd beat.
  - Exactly 4 `dcache_wnext` pulses and `bus_wlast` on 0x44.
  - `dcache_wdone` 1 cycle after `bus_bvalid`.
- **Three simultaneous requests:**
  - Fixed priority: grant order is W, DC-R, IC, with 1 IDLE cycle between each transaction.
  - With `MEM_ARB_RR_EN` and a repeated `dcache_rreq`/`icache_rreq` pair: alternates DC, IC, DC.
- **Request withdrawal:** `icache_rreq` dropped after `bus_gnt`.
  - The burst still completes 4 beats.
  - The FSM returns to IDLE with no new grant.
- **Reset during beat 2 of a DCache read:**
  - All outputs are 0 in the same cycle as reset.
  - After release, a new `dcache_rreq` restarts at R_ADDR.
- **Stray bus responses:** `bus_rvalid`/`bus_bvalid` pulses while in IDLE produce no requester output.
